// File: rtl/mem_resp_pkg.sv
// Shared constants and FSM encoding for the memory responder.
package mem_resp_pkg;

  localparam int unsigned CntWidth          = 4;
  localparam int unsigned DefaultLatency    = 2;
  localparam int unsigned DefaultDepthWords = 256;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, registered read data that holds between reads.
module mem_array #(
  parameter int unsigned Depth     = 256,
  parameter int unsigned AddrWidth = $clog2(Depth)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 we,
  input  logic                 re,
  input  logic [AddrWidth-1:0] addr,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata
);

  logic [31:0] mem_q [Depth];
  logic [31:0] rdata_q;

  // Storage is deliberately left out of reset; only the read register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[addr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re) begin
      rdata_q <= mem_q[addr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE/WAIT/RESP FSM in front of mem_array.
// Optional misalignment detection enabled by defining MEM_ALIGN_CHECK_EN.
module mem_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = DefaultDepthWords,
  parameter int unsigned LATENCY     = DefaultLatency
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        busy,
  output logic        mem_err
);

  localparam int unsigned         AddrWidth = $clog2(DEPTH_WORDS);
  localparam logic [CntWidth-1:0] CntLoad   = CntWidth'(LATENCY - 1);

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic                  we_q;
  logic [AddrWidth-1:0]  idx_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  capture, complete;
  logic                  arr_we, arr_re;
  logic                  unused_addr;

  assign capture  = (state_q == StIdle) && mem_req;
  assign complete = (state_q == StWait) && (cnt_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (mem_req) begin
          state_d = StWait;
          cnt_d   = CntLoad;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - CntWidth'(1);
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Request fields are frozen at capture so later input activity cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      we_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= mem_we;
      idx_q   <= mem_addr[AddrWidth+1:2];
      wdata_q <= mem_wdata;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (capture) begin
      err_q <= (mem_addr[1:0] != 2'b00);
    end
  end
  assign mem_err = (state_q == StResp) && err_q;
`else
  assign err_q   = 1'b0;
  assign mem_err = 1'b0;
`endif

  // Upper address bits wrap; byte offset only matters for the alignment check.
  assign unused_addr = ^{mem_addr[31:AddrWidth+2], mem_addr[1:0]};

  assign arr_we = complete && we_q && !err_q;
  assign arr_re = complete && !we_q && !err_q;

  mem_array #(
    .Depth    (DEPTH_WORDS),
    .AddrWidth(AddrWidth)
  ) u_mem_array (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (arr_we),
    .re   (arr_re),
    .addr (idx_q),
    .wdata(wdata_q),
    .rdata(mem_rdata)
  );

  assign mem_ready = (state_q == StResp);
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_mem_responder.sv
// Randomised scoreboard bench for mem_responder against a transaction-level reference model.
module tb_mem_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;
`ifdef MEM_ALIGN_CHECK_EN
  localparam bit AlignChk = 1'b1;
`else
  localparam bit AlignChk = 1'b0;
`endif

  logic        clk, rst_n, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ready, busy, mem_err;

  mem_responder #(
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata),
    .busy     (busy),
    .mem_err  (mem_err)
  );

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] model_mem [Depth];
  logic [31:0] model_rdata;
  int          cyc, next_free, resp_cyc, pend_done;
  int unsigned cap_count;
  bit          pend_valid, pend_we, m_err;
  logic [31:0] pend_addr, pend_wdata;
  int unsigned m_idx;
  int          errors = 0;
  int          checks = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference model: a request is taken when idle, completes Lat edges later, and the
  // responder is free again two edges after completion (one RESP cycle, one IDLE cycle).
  initial begin
    cyc = 0; next_free = 0; resp_cyc = -1; pend_valid = 0; cap_count = 0;
    model_rdata = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        pend_valid  = 0;
        model_rdata = '0;
        resp_cyc    = -1;
        next_free   = 0;
        exp_q.delete();
      end else begin
        cyc++;
        if (pend_valid && cyc == pend_done) begin
          m_err = AlignChk && (pend_addr % 4 != 0);
          m_idx = (pend_addr / 4) % Depth;
          if (!m_err) begin
            if (pend_we) model_mem[m_idx] = pend_wdata;
            else         model_rdata = model_mem[m_idx];
          end
          exp_q.push_back('{cyc: cyc, rdata: model_rdata, err: m_err});
          resp_cyc   = cyc;
          pend_valid = 0;
          next_free  = cyc + 2;
        end else if (!pend_valid && cyc >= next_free && mem_req === 1'b1) begin
          pend_valid = 1;
          pend_done  = cyc + Lat;
          pend_we    = mem_we;
          pend_addr  = mem_addr;
          pend_wdata = mem_wdata;
          cap_count++;
        end
      end
    end
  end

  // Monitor: compares every response and the busy/rdata behaviour against the model.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("busy", 32'(busy), 32'(pend_valid || resp_cyc == cyc));
        if (mem_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ready: got mem_ready=1 expected 0 (cycle %0d)", cyc);
          end else begin
            e = exp_q.pop_front();
            check("ready_cycle", 32'(cyc), 32'(e.cyc));
            check("resp_rdata", mem_rdata, e.rdata);
            check("resp_err", 32'(mem_err), 32'(e.err));
          end
        end else begin
          check("err_outside_resp", 32'(mem_err), 32'd0);
          if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            checks++; errors++;
            $display("FAIL missing_ready: got mem_ready=0 expected 1 (cycle %0d)", exp_q[0].cyc);
            void'(exp_q.pop_front());
          end
        end
        check("rdata_hold", mem_rdata, model_rdata);
      end
    end
  end

  task automatic issue(input bit we, input logic [31:0] addr, input logic [31:0] wdata);
    int unsigned c0;
    bit got;
    @(negedge clk);
    c0 = cap_count; got = 0;
    mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      #1;
      if (cap_count != c0) got = 1;
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL capture_timeout: got no capture expected capture of addr 0x%08h", addr);
    end
    // Scramble inputs right after capture; the access in flight must not notice.
    @(negedge clk);
    mem_req = 1'b0; mem_we = 1'($urandom); mem_addr = $urandom; mem_wdata = $urandom;
  endtask

  task automatic settle();
    repeat (Lat + 1) @(negedge clk);
  endtask

  initial begin
    logic [31:0] old;
    logic [31:0] a;
    rst_n = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(mem_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(mem_err), 32'd0);
    check("rst_rdata", mem_rdata, 32'd0);
    #2 rst_n = 1'b1;

    // Fill every word, using random upper address bits to exercise wrap-around.
    for (int i = 0; i < int'(Depth); i++) begin
      a = ($urandom & 32'hFFFF_FC00) | 32'(i * 4);
      issue(1'b1, a, $urandom);
    end

    issue(1'b1, 32'h10, 32'hDEAD_BEEF);
    issue(1'b0, 32'h10, 32'h0);
    settle();
    check("read_0x10", mem_rdata, 32'hDEAD_BEEF);
    issue(1'b1, 32'h14, 32'h1234_5678);
    settle();
    check("write_keeps_rdata", mem_rdata, 32'hDEAD_BEEF);

    issue(1'b1, 32'h0, 32'h1);
    issue(1'b0, 32'h400, 32'h0);
    settle();
    check("wrap_read_0x400", mem_rdata, 32'h1);

    // Reset while a write to 0x20 is waiting: the write must be dropped.
    old = model_mem[8];
    issue(1'b1, 32'h20, 32'hCAFE_F00D);
    #2 rst_n = 1'b0;
    #1;
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_ready", 32'(mem_ready), 32'd0);
    check("rst_wait_rdata", mem_rdata, 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    issue(1'b0, 32'h20, 32'h0);
    settle();
    check("rst_discard_0x20", mem_rdata, old);

    old = model_mem[8];
    issue(1'b1, 32'h22, 32'h5555_AAAA);
    issue(1'b0, 32'h20, 32'h0);
    settle();
    check("misaligned_write", mem_rdata, AlignChk ? old : 32'h5555_AAAA);

    for (int i = 0; i < 200; i++) begin
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      issue(1'($urandom), a, $urandom);
      repeat ($urandom_range(2)) @(negedge clk);
    end

    // Continuous request: captures must be spaced by the responder, never queued.
    @(negedge clk);
    mem_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      mem_we = 1'($urandom); mem_addr = $urandom & 32'h0000_00FC; mem_wdata = $urandom;
      @(negedge clk);
    end
    mem_req = 1'b0;

    repeat (Lat + 4) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected finish before time limit");
    $fatal(1);
  end

endmodule
